ex_hazard_forward_unit: RTL and testbench
=========================================

# ex_hazard_forward_unit

Producer of the forwarding selects consumed by the EX-stage ALU operand muxes, plus the load-use stall logic for the 5-stage pipeline. It keeps its own registered copies of the EX/MEM and MEM/WB destination tags. It drives ForwardA/ForwardB with the encoding the EX stage decodes: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB data. A small FSM inserts exactly one bubble for each load-use hazard and is cleared by branch flush.

## Interface
- REG_ADDR_W, 5: register index width.
- STAT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- pipe_hold  in  1  global freeze (memory wait); no state updates while high.
- branch_flush  in  1  branch taken/mispredict, kills ID and EX.
- id_valid  in  1  ID-stage instruction valid.
- id_rs, id_rt  in  REG_ADDR_W  ID-stage source registers.
- ex_valid  in  1  ID/EX instruction valid.
- ex_rs, ex_rt  in  REG_ADDR_W  EX-stage source registers.
- ex_rd  in  REG_ADDR_W  EX-stage destination.
- ex_reg_write, ex_mem_read  in  1  EX-stage control.
- forward_a, forward_b  out  2  operand select codes for the EX muxes.
- stall  out  1  hold PC and IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- stall_cnt, fwd_cnt  out  STAT_W  statistics counters.
- stat_clr  in  1  synchronous clear of both counters.

## Operation
- Shadow tags: mem_{rd,wr,ld} and wb_{rd,wr} registers.
  - At each edge without pipe_hold: mem_* <= ex_* gated by ex_valid, and wb_* <= mem_*.
  - A tag is "live" when its wr bit is 1 and its rd is not 0.
- forward_a:
  - 10 if the mem tag is live and mem_rd == ex_rs.
  - Otherwise 01 if the wb tag is live and wb_rd == ex_rs.
  - Otherwise 00.
  - EX/MEM always has priority over MEM/WB.
- forward_b: same rule applied to ex_rt.
- Both forward outputs are forced to 00 when ex_valid = 0.
- Hazard condition: ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs | ex_rd == id_rt).
- FSM states RUN and STALL.
  - RUN: on hazard, stall = 1 and id_ex_bubble = 1 in that same cycle; next state is STALL.
  - STALL: stall = 0 and bubble = 0; hazard detection is masked; next state is RUN. This guarantees exactly one bubble per load.
  - branch_flush overrides both: stall = 0, bubble = 1, next state is RUN.
  - pipe_hold: state and tags hold; stall and bubble outputs are held at 0.
- Register 0 is never forwarded and never causes a stall.
- Reset values:
  - Tags cleared, FSM in RUN.
  - forward_a = forward_b = 00, stall = 0, id_ex_bubble = 0.
  - Both counters 0.

## Timing
- forward_a/b: combinational from the registered tags and the current ex_* inputs, valid in the same cycle.
- stall/bubble: combinational in the cycle the hazard is visible. The dependent instruction sees the loaded value via the 01 code two cycles after the load was in EX.
- Tags update one cycle per stage, so EX→MEM→WB visibility is 1 and 2 cycles respectively.
- Reset asserted mid-stall returns the FSM to RUN immediately and drops stall asynchronously.
- Simultaneous hazard and branch_flush: the flush wins, with no STALL entry.
- Simultaneous stat_clr and a counted event: the clear wins.

## Configuration
- FWD_STATS_EN defined:
  - stall_cnt increments on each cycle with stall = 1.
  - fwd_cnt increments on each cycle where forward_a or forward_b is non-zero, counting at most +1 per cycle.
  - Both counters saturate at all-ones, are cleared by stat_clr, and are frozen by pipe_hold.
- FWD_STATS_EN undefined: no counter logic; stall_cnt and fwd_cnt are tied to 0. The ports remain present.

## Structure
- Shared package holds:
  - Forward codes FWD_REG = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01.
  - FSM state encoding ST_RUN and ST_STALL.
  - Default REG_ADDR_W.
- Sub-module fwd_sel_cmp: pure comparator taking (src, mem tag, wb tag, valid) and returning a 2-bit code. It is instantiated twice, for A and B.
- FSM, tag registers and counters live in the top.

## Test plan
- EX/MEM forward: add r3 in EX, then sub using r3 as rs. Next cycle forward_a = 10 and forward_b = 00.
- Double hazard: r3 live in both MEM (newer) and WB, with ex_rs = ex_rt = 3 → forward_a = forward_b = 10.
- Load-use: lw r5 in EX with id_rs = 5 → stall = 1 and id_ex_bubble = 1 for exactly one cycle. Two cycles later forward_a = 01.
- r0 writer: ex_rd = 0 with reg_write = 1, then consumer with rs = 0 → forward_a = 00 and no stall.
- Hazard plus branch_flush in the same cycle → stall = 0, id_ex_bubble = 1, FSM in RUN. With FWD_STATS_EN, stall_cnt is unchanged.
- Reset pulse during STALL → all outputs return to reset values asynchronously.
- Counter check: STAT_W = 4 with 20 forwarding cycles → fwd_cnt saturates at 15. stat_clr then returns it to 0.

Source files
------------

// File: rtl/ex_hazard_forward_unit_pkg.sv
// Shared constants for the EX-stage forwarding and load-use stall logic.
// Holds the forward select encoding and the stall FSM state encoding.
package ex_hazard_forward_unit_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/ex_hazard_forward_unit_fwd_sel_cmp.sv
// Forward select comparator for one ALU operand.
// EX/MEM wins over MEM/WB; register 0 never forwards.
module fwd_sel_cmp
    import ex_hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_wr,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_wr,
    input  logic                  valid,
    output logic [1:0]            code
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = valid & mem_wr & (mem_rd != '0) & (mem_rd == src);
    assign wb_hit  = valid & wb_wr & (wb_rd != '0) & (wb_rd == src)
                   & ~mem_hit;

    always_comb begin
        code = FWD_REG;
        unique case (1'b1)
            mem_hit: code = FWD_EXMEM;
            wb_hit:  code = FWD_MEMWB;
            default: code = FWD_REG;
        endcase
    end

endmodule

// File: rtl/ex_hazard_forward_unit.sv
// EX-stage forward selects plus one-bubble load-use stall FSM.
// Define FWD_STATS_EN to build the stall/forward statistics counters.
module ex_hazard_forward_unit
    import ex_hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_hold,
    input  logic                  branch_flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic                  id_ex_bubble,
    output logic [STAT_W-1:0]     stall_cnt,
    output logic [STAT_W-1:0]     fwd_cnt,
    input  logic                  stat_clr
);

    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_wr;
    logic                  mem_ld;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_wr;
    hz_state_t             state;
    hz_state_t             state_n;
    logic                  hazard;
    logic                  stall_c;
    logic                  bubble_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd <= '0;
            mem_wr <= 1'b0;
            mem_ld <= 1'b0;
            wb_rd  <= '0;
            wb_wr  <= 1'b0;
        end else if (!pipe_hold) begin
            mem_rd <= ex_rd;
            mem_wr <= ex_valid & ex_reg_write;
            mem_ld <= ex_valid & ex_mem_read;
            wb_rd  <= mem_rd;
            wb_wr  <= mem_wr;
        end
    end

    // Load flag travels with the tag for waveform debug only.
    logic unused_mem_ld;
    assign unused_mem_ld = mem_ld;

    fwd_sel_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_a (
        .src    (ex_rs),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .wb_rd  (wb_rd),
        .wb_wr  (wb_wr),
        .valid  (ex_valid),
        .code   (forward_a)
    );

    fwd_sel_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_b (
        .src    (ex_rt),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .wb_rd  (wb_rd),
        .wb_wr  (wb_wr),
        .valid  (ex_valid),
        .code   (forward_b)
    );

    assign hazard = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid
                  & ((ex_rd == id_rs) | (ex_rd == id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        if (!pipe_hold) begin
            if (branch_flush) begin
                bubble_c = 1'b1;
                state_n  = ST_RUN;
            end else begin
                unique case (state)
                    ST_RUN: begin
                        if (hazard) begin
                            stall_c  = 1'b1;
                            bubble_c = 1'b1;
                            state_n  = ST_STALL;
                        end
                    end
                    ST_STALL: state_n = ST_RUN;
                    default:  state_n = ST_RUN;
                endcase
            end
        end
    end

    // Reset must drop the stall request without waiting for a clock.
    assign stall        = stall_c & rst_n;
    assign id_ex_bubble = bubble_c & rst_n;

`ifdef FWD_STATS_EN
    logic fwd_any;
    assign fwd_any = (forward_a != FWD_REG) | (forward_b != FWD_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!pipe_hold) begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (fwd_any && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 1'b1;
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stall_cnt       = '0;
    assign fwd_cnt         = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_forward_unit.sv
// Directed bench for ex_hazard_forward_unit.
// Counter expectations follow FWD_STATS_EN when it is defined.
module tb_ex_hazard_forward_unit;

    localparam int RW = 5;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pipe_hold;
    logic          branch_flush;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt;
    logic          ex_valid;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
    logic          ex_reg_write, ex_mem_read;
    logic [1:0]    forward_a, forward_b;
    logic          stall, id_ex_bubble;
    logic [SW-1:0] stall_cnt, fwd_cnt;
    logic          stat_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_hazard_forward_unit #(.REG_ADDR_W(RW), .STAT_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_hold    (pipe_hold),
        .branch_flush (branch_flush),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_valid     (ex_valid),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall        (stall),
        .id_ex_bubble (id_ex_bubble),
        .stall_cnt    (stall_cnt),
        .fwd_cnt      (fwd_cnt),
        .stat_clr     (stat_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic ex_set(input logic v, input logic [RW-1:0] rs,
                          input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                          input logic wr, input logic ld);
        ex_valid     = v;
        ex_rs        = rs;
        ex_rt        = rt;
        ex_rd        = rd;
        ex_reg_write = wr;
        ex_mem_read  = ld;
    endtask

    logic [SW-1:0] exp_sat;

    initial begin
`ifdef FWD_STATS_EN
        exp_sat = '1;
`else
        exp_sat = '0;
`endif
        rst_n = 1'b0; pipe_hold = 1'b0; branch_flush = 1'b0;
        stat_clr = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0;
        ex_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(); #1;
        chk("rst_fwd_a", 32'(forward_a), 32'd0);
        chk("rst_fwd_b", 32'(forward_b), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bubble", 32'(id_ex_bubble), 32'd0);
        chk("rst_cnts", {stall_cnt, fwd_cnt}, 32'd0);
        rst_n = 1'b1;

        // add r3 in EX, then sub r3 consumer
        step(); ex_set(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); #1;
        chk("no_tag_fwd_a", 32'(forward_a), 32'd0);
        step(); ex_set(1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0); #1;
        chk("exmem_fwd_a", 32'(forward_a), 32'b10);
        chk("exmem_fwd_b", 32'(forward_b), 32'b00);
        // r3 now only in WB
        step(); ex_set(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0); #1;
        chk("memwb_fwd_a", 32'(forward_a), 32'b01);
        chk("memwb_fwd_b", 32'(forward_b), 32'b01);
        step(); #1;
        chk("exmem_r3_b", 32'(forward_b), 32'b10);
        // r3 in both MEM and WB
        step(); ex_set(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0); #1;
        chk("double_a", 32'(forward_a), 32'b10);
        chk("double_b", 32'(forward_b), 32'b10);
        ex_valid = 1'b0; #1;
        chk("invalid_ab", {forward_a, forward_b}, 32'd0);

        // r0 load writer never stalls
        step(); ex_set(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1);
        id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0; #1;
        chk("r0_no_stall", 32'(stall), 32'd0);
        step(); ex_set(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0); #1;
        chk("r0_no_fwd", {forward_a, forward_b}, 32'd0);

        // lw r5 with dependent in ID
        step(); ex_set(1'b1, 5'd7, 5'd8, 5'd5, 1'b1, 1'b1);
        id_rs = 5'd5; id_rt = 5'd9; #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
        step(); ex_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
        chk("lu_one_shot", {stall, id_ex_bubble}, 32'd0);
        step(); ex_set(1'b1, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0);
        id_valid = 1'b0; #1;
        chk("lu_memwb_a", 32'(forward_a), 32'b01);
        chk("lu_after_stall", 32'(stall), 32'd0);

        // hazard plus flush: flush wins
        step(); ex_set(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd7; branch_flush = 1'b1; #1;
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_bubble", 32'(id_ex_bubble), 32'd1);
        step(); branch_flush = 1'b0; #1;
        chk("flush_run_stall", 32'(stall), 32'd1);
        pipe_hold = 1'b1; #1;
        chk("hold_outs", {stall, id_ex_bubble}, 32'd0);
        step(); pipe_hold = 1'b0; ex_rs = 5'd7; ex_rt = 5'd10; #1;
        chk("hold_state", 32'(stall), 32'd1);
        chk("hold_tags", {forward_a, forward_b}, 32'b1001);

        // async reset in STALL and while stalling in RUN
        step(); #1;
        chk("in_stall", 32'(stall), 32'd0);
        chk("pre_rst_a", 32'(forward_a), 32'b10);
        rst_n = 1'b0; #1;
        chk("rst_mid_fwd", {forward_a, forward_b}, 32'd0);
        chk("rst_mid_outs", {stall, id_ex_bubble}, 32'd0);
        rst_n = 1'b1; #1;
        chk("rst_to_run", 32'(stall), 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_drop_stall", 32'(stall), 32'd0);
        step(); rst_n = 1'b1;

        // forward statistics saturation and clear
        id_valid = 1'b0;
        ex_set(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step();
        #1;
        chk("fwd_cnt_sat", 32'(fwd_cnt), 32'(exp_sat));
        chk("stall_cnt_zero", 32'(stall_cnt), 32'd0);
        stat_clr = 1'b1;
        step(); stat_clr = 1'b0; #1;
        chk("fwd_cnt_clr", 32'(fwd_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
